spike_train_gen: RTL and testbench
==================================

SPIKE_TRAIN_GEN -- requirements
Module: spike_train_gen

Interface
REQ-001 Parameter: IVL_W, default 8, width of the inter-spike interval field.
REQ-002 Parameter: CNT_W, default 8, width of the spike count field and the sent counter.
REQ-003 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port: rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port: start, input, 1, request to launch a spike train; sampled only in IDLE.
REQ-006 Port: interval, input, IVL_W, cycles between spike rising edges; latched on acceptance.
REQ-007 Port: count, input, CNT_W, number of spikes in the train; latched on acceptance.
REQ-008 Port: abort, input, 1, terminates the active train.
REQ-009 Port: spike_out, output, 1, single-cycle spike pulse that feeds downstream delay/neuron inputs.
REQ-010 Port: busy, output, 1, high from the cycle after acceptance until the train ends.
REQ-011 Port: done, output, 1, single-cycle pulse on normal completion.
REQ-012 Port: sent, output, CNT_W, spikes emitted in the current or most recent train.

Function
REQ-013 FSM states SHALL be IDLE, FIRE, WAIT, DONE.
REQ-014 IDLE with start=1 and abort=0 SHALL accept the request: latch interval and count, clear sent, and go to FIRE when count!=0, or to DONE when count==0.
REQ-015 FIRE SHALL assert spike_out for exactly one cycle, increment sent, and load the interval timer.
REQ-016 The first spike SHALL appear exactly 1 cycle after the acceptance edge.
REQ-017 After FIRE, the FSM SHALL go to DONE when sent reaches count; otherwise it SHALL go to WAIT.
REQ-018 WAIT SHALL return to FIRE so that consecutive spike rising edges are exactly max(interval,1) cycles apart.
REQ-019 interval==0 SHALL behave as interval==1, giving back-to-back spikes.
REQ-020 DONE SHALL assert done for one cycle, deassert busy, and return to IDLE.
REQ-021 done SHALL pulse once even when count==0; no spike SHALL be emitted in that case.
REQ-022 start while busy SHALL be ignored; no request SHALL be queued.
REQ-023 Changes to interval or count while busy SHALL have no effect on the active train.
REQ-024 abort in FIRE, WAIT or DONE SHALL force IDLE on the next edge.
REQ-025 After abort, spike_out SHALL be 0 from that edge onward, no done pulse SHALL follow, and sent SHALL hold its value.
REQ-026 abort and start together in IDLE: abort SHALL win and the request SHALL NOT be accepted.
REQ-027 abort coincident with a FIRE cycle SHALL still let that spike complete; no further spike SHALL follow.
REQ-028 sent SHALL NOT wrap, since it is bounded by count and count is at most 2^CNT_W-1.
REQ-029 The timer SHALL be IVL_W bits wide and SHALL never underflow.
REQ-030 All outputs SHALL be registered; spike_out SHALL NOT be gated by clk.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, spike_out=0, busy=0, done=0, sent=0, timer=0, latched fields=0.
REQ-032 rst asserted mid-train SHALL discard the train with no done pulse.
REQ-033 After rst deasserts, the first start SHALL be sampled on the next rising edge.

Structure
REQ-034 Shared package spike_pkg SHALL hold the state enum type and the default IVL_W/CNT_W constants.
REQ-035 One sub-module, spike_interval_timer, SHALL provide the loadable down-counter with an expiry flag.
REQ-036 The FSM, the sent counter and the output registers SHALL reside in spike_train_gen.

Verification
REQ-037 Scenario: interval=4, count=3, one start pulse -> spikes at cycles +1, +5, +9 after acceptance; done at +10; sent=3.
REQ-038 Scenario: interval=0, count=4 -> four spikes on consecutive cycles +1..+4; done at +5.
REQ-039 Scenario: count=0 -> no spike; busy high 1 cycle; done at +1; sent=0.
REQ-040 Scenario: interval=5, count=10, abort after 2nd spike -> no further spikes; no done; sent=2; IDLE next cycle.
REQ-041 Scenario: second start plus changed interval mid-train -> ignored; original spacing and count preserved.
REQ-042 Scenario: rst pulsed during WAIT -> all outputs 0 immediately; new start afterwards runs a clean train.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike train generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spike_pkg;

    localparam int IVL_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spike_interval_timer.sv
// Loadable saturating down-counter; expired marks the last cycle of a wait.
// Latency: load value visible the cycle after load; expired is combinational from the count.
// Backpressure: none; load overrides counting, count holds at zero.
module spike_interval_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and stop at zero so it never underflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // A count of one (or zero) means the next edge should fire again.
    always_comb begin
        expired = (cnt <= W'(1));
    end

endmodule

// File: rtl/spike_train_gen.sv
// Emits a train of count single-cycle spikes spaced max(interval,1) cycles apart.
// Latency: first spike 1 cycle after the acceptance edge; done 1 cycle after the last spike.
// Backpressure: none; start is ignored while busy, abort cancels the train without a done pulse.
module spike_train_gen
    import spike_pkg::*;
#(
    parameter int IVL_W = IVL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IVL_W-1:0] interval,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             spike_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    state_t             state;
    state_t             next_state;
    logic [IVL_W-1:0]   ivl_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   sent_inc;
    logic [IVL_W-1:0]   tmr_load_val;
    logic               tmr_load;
    logic               tmr_expired;
    logic               accept;
    logic               spike_d;
    logic               busy_d;
    logic               done_d;

    // Request acceptance, spike bookkeeping and timer reload value.
    always_comb begin
        accept       = (state == IDLE) && start && !abort;
        sent_inc     = sent + CNT_W'(1);
        tmr_load     = (state == FIRE);
        // An interval of zero is treated as one, so the wait collapses to nothing.
        tmr_load_val = (ivl_q == '0) ? '0 : ivl_q - IVL_W'(1);
    end

    spike_interval_timer #(
        .W (IVL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .expired  (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort always returns to IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (count == '0) ? DONE : FIRE;
                end
            end
            FIRE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (sent_inc == cnt_q) begin
                    next_state = DONE;
                end else if (ivl_q <= IVL_W'(1)) begin
                    next_state = FIRE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (tmr_expired) begin
                    next_state = FIRE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode; a FIRE cycle always completes its spike even under abort.
    always_comb begin
        spike_d = (state == FIRE);
        done_d  = (state == DONE) && !abort;
        busy_d  = (next_state != IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            spike_out <= spike_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Latch the train parameters on acceptance and count emitted spikes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivl_q <= '0;
            cnt_q <= '0;
            sent  <= '0;
        end else if (accept) begin
            ivl_q <= interval;
            cnt_q <= count;
            sent  <= '0;
        end else if (state == FIRE) begin
            sent  <= sent_inc;
        end
    end

endmodule

// File: tb/tb_spike_train_gen.sv
module tb_spike_train_gen;

    localparam int IW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] interval;
    logic [CW-1:0] count;
    logic          abort;
    logic          spike_out;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent;

    spike_train_gen #(
        .IVL_W (IW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .interval  (interval),
        .count     (count),
        .abort     (abort),
        .spike_out (spike_out),
        .busy      (busy),
        .done      (done),
        .sent      (sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        checks++;
        if (obs !== 32'(exp_v)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference model: a train accepted at edge k with spacing m and c spikes
    // has its spikes after edges k+1+i*m, and done after edge k+tdone.
    int cyc    = 0;
    bit act    = 1'b0;
    int k      = 0;
    int m      = 1;
    int c      = 0;
    int sent_m = 0;

    function automatic int tdone_f(input int cc, input int mm);
        return (cc == 0) ? 1 : (cc - 1) * mm + 2;
    endfunction

    function automatic bit spike_at(input int t, input int cc, input int mm);
        if (t < 1) return 1'b0;
        return ((t - 1) % mm == 0) && ((t - 1) / mm < cc);
    endfunction

    function automatic int sent_at(input int t, input int cc, input int mm);
        int n;
        if (cc == 0 || t < 1) return 0;
        n = (t - 1) / mm + 1;
        return (n > cc) ? cc : n;
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model, compare.
    task automatic step(input bit s, input int ivl, input int cn, input bit ab);
        bit pb;
        int t;
        bit es;
        bit ed;
        bit eb;
        start    = s;
        interval = ivl[IW-1:0];
        count    = cn[CW-1:0];
        abort    = ab;
        @(posedge clk);
        cyc++;
        pb = act && ((cyc - 1 - k) < tdone_f(c, m));
        es = 1'b0;
        ed = 1'b0;
        eb = 1'b0;
        if (pb) begin
            t      = cyc - k;
            es     = spike_at(t, c, m);
            sent_m = sent_at(t, c, m);
            if (ab) begin
                act = 1'b0;
            end else begin
                ed = (t == tdone_f(c, m));
                eb = (t < tdone_f(c, m));
            end
        end else begin
            act = 1'b0;
            if (s && !ab) begin
                act    = 1'b1;
                k      = cyc;
                m      = (ivl[IW-1:0] == 0) ? 1 : int'(ivl[IW-1:0]);
                c      = int'(cn[CW-1:0]);
                sent_m = 0;
                eb     = 1'b1;
            end
        end
        #1;
        chk("spike_out", 32'(spike_out), int'(es));
        chk("busy",      32'(busy),      int'(eb));
        chk("done",      32'(done),      int'(ed));
        chk("sent",      32'(sent),      sent_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
        end
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_spike", 32'(spike_out), 0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_done",  32'(done),      0);
        chk("rst_sent",  32'(sent),      0);
        act    = 1'b0;
        sent_m = 0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        interval = '0;
        count    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_spike", 32'(spike_out), 0);
        chk("reset_busy",  32'(busy),      0);
        chk("reset_done",  32'(done),      0);
        chk("reset_sent",  32'(sent),      0);
        rst = 1'b0;

        // interval 4, count 3
        step(1'b1, 4, 3, 1'b0);
        idle(12);
        // interval 0 -> back-to-back spikes
        step(1'b1, 0, 4, 1'b0);
        idle(7);
        // count 0 -> done only
        step(1'b1, 9, 0, 1'b0);
        idle(3);
        // abort during the wait after the second spike
        step(1'b1, 5, 10, 1'b0);
        idle(7);
        step(1'b0, 0, 0, 1'b1);
        idle(5);
        // second start with new parameters while busy is ignored
        step(1'b1, 3, 4, 1'b0);
        idle(2);
        step(1'b1, 1, 9, 1'b0);
        idle(15);
        // reset during the wait, then a clean train
        step(1'b1, 6, 3, 1'b0);
        idle(3);
        do_reset();
        step(1'b1, 2, 2, 1'b0);
        idle(6);
        // abort and start together in IDLE: abort wins
        step(1'b1, 2, 2, 1'b1);
        idle(3);
        // abort coincident with the first FIRE cycle
        step(1'b1, 3, 5, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit s;
            bit ab;
            int ivl;
            int cn;
            s   = ($urandom_range(0, 3) == 0);
            ab  = ($urandom_range(0, 39) == 0);
            ivl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
            cn  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 5));
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            step(s, ivl, cn, ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
